// File: rtl/convolution_stage2_if.sv
// Product/result bundle between the multiplication stage, the accumulation
// stage and the downstream writer.
interface convolution_stage2_if #(
    parameter int CNT_W = 16
) ();
    logic                    in_valid;
    logic                    frame_start;
    logic signed [4:0]       prod1;
    logic signed [4:0]       prod2;
    logic        [5:0]       prod3;
    logic signed [4:0]       prod4;
    logic signed [4:0]       prod5;
    logic signed [7:0]       sum_out;
    logic                    out_valid;
    logic                    edge_flag;
    logic        [CNT_W-1:0] pix_count;

    modport master (
        output in_valid, frame_start, prod1, prod2, prod3, prod4, prod5,
        input  sum_out, out_valid, edge_flag, pix_count
    );

    modport slave (
        input  in_valid, frame_start, prod1, prod2, prod3, prod4, prod5,
        output sum_out, out_valid, edge_flag, pix_count
    );
endinterface

// File: rtl/convolution_stage2.sv
// Laplacian accumulation stage: two-cycle adder tree, edge threshold flag and
// per-frame result counter. Optional macro CONV2_RELU_EN clamps sum_out at 0.
module convolution_stage2 #(
    parameter int EDGE_THRESH = 32,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    convolution_stage2_if.slave bus
);
    localparam logic [7:0] THRESH_U = 8'(EDGE_THRESH);

    logic signed [4:0] nb_prod [4];
    logic signed [5:0] pair_next [2];

    logic signed [5:0] a0_reg;
    logic signed [5:0] a1_reg;
    logic        [7:0] a2_reg;
    logic              va_reg;

    logic [7:0]       raw_next;
    logic [7:0]       neg_next;
    logic [6:0]       mag_next;
    logic             edge_next;
    logic [7:0]       sum_next;

    logic [7:0]       sum_reg;
    logic             valid_reg;
    logic             edge_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign nb_prod[0] = bus.prod1;
    assign nb_prod[1] = bus.prod2;
    assign nb_prod[2] = bus.prod4;
    assign nb_prod[3] = bus.prod5;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pair
            assign pair_next[gi] = {nb_prod[2*gi][4], nb_prod[2*gi]}
                                 + {nb_prod[2*gi+1][4], nb_prod[2*gi+1]};
        end
    endgenerate

    // Stage A: bubbles load zeros so stage B never sees stale operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a0_reg <= '0;
            a1_reg <= '0;
            a2_reg <= '0;
            va_reg <= 1'b0;
        end else begin
            va_reg <= bus.in_valid;
            if (bus.in_valid) begin
                a0_reg <= pair_next[0];
                a1_reg <= pair_next[1];
                a2_reg <= {2'b00, bus.prod3};
            end else begin
                a0_reg <= '0;
                a1_reg <= '0;
                a2_reg <= '0;
            end
        end
    end

    // Sum spans -60..+60, so 8 bits never overflow and 7 bits hold |raw|.
    always_comb begin
        raw_next  = {{2{a0_reg[5]}}, a0_reg} + {{2{a1_reg[5]}}, a1_reg} + a2_reg;
        neg_next  = 8'd0 - raw_next;
        mag_next  = raw_next[7] ? neg_next[6:0] : raw_next[6:0];
        edge_next = va_reg && ({1'b0, mag_next} >= THRESH_U);
`ifdef CONV2_RELU_EN
        sum_next  = raw_next[7] ? 8'd0 : raw_next;
`else
        sum_next  = raw_next;
`endif
        if (!va_reg) begin
            sum_next = 8'd0;
        end
    end

    // Stage B plus the counter; frame_start with a completing result starts at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg   <= '0;
            valid_reg <= 1'b0;
            edge_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sum_reg   <= sum_next;
            valid_reg <= va_reg;
            edge_reg  <= edge_next;
            if (bus.frame_start) begin
                cnt_reg <= va_reg ? CNT_W'(1) : '0;
            end else if (va_reg) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.sum_out   = sum_reg;
    assign bus.out_valid = valid_reg;
    assign bus.edge_flag = edge_reg;
    assign bus.pix_count = cnt_reg;
endmodule
